// File: rtl/hex_scan_streamer_pkg.sv
// Shared types and constants for the hex scan streamer and its companion X/Y hex decoder.
package hex_scan_streamer_pkg;

    localparam int C_HEX_DECODER_LATENCY      = 4;
    localparam int C_HEX_DECODER_LATENCY_COMB = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } scan_state_t;

    // Per-issue tag travelling alongside the decoder pipeline.
    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } pix_tag_t;

endpackage

// File: rtl/hex_pixel_fifo.sv
// Synchronous first-word-fall-through FIFO; the head word is visible whenever empty is low.
module hex_pixel_fifo #(
    parameter int width = 18,
    parameter int depth = 8,
    localparam int aw   = $clog2(depth)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [width-1:0] push_data,
    input  logic             pop,
    output logic [width-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [aw:0]      count
);

    localparam logic [aw:0] c_depth = depth[aw:0];

    logic [width-1:0] mem [depth];
    logic [aw:0]      wr_ptr;
    logic [aw:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == c_depth);
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (aw+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (aw+1)'(1);
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which words are meaningful.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[aw-1:0]] <= push_data;
    end

    assign pop_data = empty ? '0 : mem[rd_ptr[aw-1:0]];

endmodule

// File: rtl/hex_scan_streamer.sv
// Scans an x/y window into a fixed-latency hex decoder and streams the returned colors
// through a FWFT FIFO, issuing only against guaranteed FIFO space because the decoder cannot stall.
module hex_scan_streamer
    import hex_scan_streamer_pkg::*;
#(
    parameter int c_x_bits     = 7,
    parameter int c_y_bits     = 7,
    parameter int c_x_size     = 128,
    parameter int c_y_size     = 64,
    parameter int c_color_bits = 16,
    parameter int c_latency    = C_HEX_DECODER_LATENCY,
    parameter int c_fifo_depth = 8,
    parameter int c_continuous = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    start,
    output logic [c_x_bits-1:0]     x,
    output logic [c_y_bits-1:0]     y,
    input  logic [c_color_bits-1:0] color_in,
    output logic [c_color_bits-1:0] pix_data,
    output logic                    pix_first,
    output logic                    pix_last,
    output logic                    pix_valid,
    input  logic                    pix_ready,
    output logic                    busy
);

    localparam int c_cnt_bits = $clog2(c_fifo_depth) + 1;
    localparam int c_if_bits  = $clog2(c_latency + 1) + 1;
    localparam bit c_comb     = (c_latency == C_HEX_DECODER_LATENCY_COMB);

    scan_state_t           state;
    scan_state_t           state_next;
    pix_tag_t              issue_tag;
    pix_tag_t              out_tag;
    logic                  issue;
    logic                  push;
    logic                  credit_ok;
    logic                  at_x_end;
    logic                  at_y_end;
    logic [c_if_bits-1:0]  in_flight;
    logic [c_cnt_bits-1:0] fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;

    assign at_x_end = (x == c_x_bits'(c_x_size - 1));
    assign at_y_end = (y == c_y_bits'(c_y_size - 1));

    // Pixels already issued into the decoder own a FIFO slot they will land in later.
    assign credit_ok = (c_fifo_depth - int'(fifo_count)) > int'(in_flight);
    assign issue     = (state == ST_SCAN) & credit_ok & ~fifo_full;

    assign issue_tag = '{valid: issue,
                         first: (x == '0) && (y == '0),
                         last:  at_x_end && at_y_end};

    generate
        if (c_comb) begin : g_tag_comb
            assign out_tag = issue_tag;
        end else begin : g_tag_pipe
            pix_tag_t pipe [c_latency];

            always_ff @(posedge clk) begin
                if (!resetn) begin
                    for (int i = 0; i < c_latency; i++) pipe[i] <= '0;
                end else begin
                    pipe[0] <= issue_tag;
                    for (int i = 1; i < c_latency; i++) pipe[i] <= pipe[i-1];
                end
            end

            assign out_tag = pipe[c_latency-1];
        end
    endgenerate

    assign push = out_tag.valid;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            in_flight <= '0;
        end else if (issue && !push) begin
            in_flight <= in_flight + c_if_bits'(1);
        end else if (!issue && push) begin
            in_flight <= in_flight - c_if_bits'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            x <= '0;
            y <= '0;
        end else if (issue) begin
            if (at_x_end) begin
                x <= '0;
                y <= at_y_end ? '0 : y + c_y_bits'(1);
            end else begin
                x <= x + c_x_bits'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_next;
    end

    // NOTE: the default assignment first keeps every path of this block from inferring a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (c_continuous != 0 || start) state_next = ST_SCAN;
            ST_SCAN:  if (issue && issue_tag.last && c_continuous == 0) state_next = ST_DRAIN;
            ST_DRAIN: if (in_flight == '0 && fifo_empty) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);

    hex_pixel_fifo #(
        .width (c_color_bits + 2),
        .depth (c_fifo_depth)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push),
        .push_data ({color_in, out_tag.first, out_tag.last}),
        .pop       (pix_ready),
        .pop_data  ({pix_data, pix_first, pix_last}),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign pix_valid = ~fifo_empty;

endmodule
